// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the shift-and-add multiply
// sequencer.
//   state_t : controller FSM encoding (IDLE, CALC, DONE)
//   WIDTH   : operand width, equal to the shared adder width
//   CNT_W   : iteration counter width (2**CNT_W > WIDTH)
//   PROD_W  : product width (2*WIDTH)
package mul_seq_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: unsigned WIDTH x WIDTH -> 2*WIDTH multiply by shift-and-add.
// The WIDTH-bit adder lives in the parent and is time-shared with other ALU
// operations; the parent gives this block priority on the adder while busy=1.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand request handshake; op_a multiplicand,
//                        op_b multiplier
//   out_valid/out_ready  product response handshake; product held until taken
//   busy                 high in CALC or DONE
//   add_a, add_b,
//   add_cin, add_en      drive the shared adder (ADD mode, cin tied to 0)
//   add_sum, add_cout    result returned by the shared adder
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = mul_seq_pkg::WIDTH,
  parameter int unsigned CNT_W = mul_seq_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  output logic                 add_en,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  import mul_seq_pkg::*;

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q;
  logic [PW-1:0]    p_q;     // {A, Q}
  logic [CNT_W-1:0] cnt_q;

  // One shift-and-add iteration. The adder sees add_a=A and add_b=M this
  // cycle because both are registered one step ahead of their use.
  logic [WIDTH-1:0] a_cur;
  logic [WIDTH-1:0] a_new;
  logic             c_new;
  logic [PW-1:0]    p_step;

  always_comb begin
    a_cur = p_q[PW-1:WIDTH];
    a_new = a_cur;
    c_new = 1'b0;
    if (p_q[0]) begin
      a_new = add_sum;
      c_new = add_cout;
    end
    // {c, A', Q} >> 1, low 2*WIDTH bits: the carry lands in the MSB.
    p_step = {c_new, a_new, p_q[WIDTH-1:1]};
  end

  assign add_cin = 1'b0;

  // add_b doubles as the multiplicand register M: it is loaded at accept
  // and only needs to be visible while CALC runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      add_en    <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            p_q      <= {{WIDTH{1'b0}}, op_b};
            cnt_q    <= '0;
            state_q  <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            add_en   <= 1'b1;
            add_a    <= '0;
            add_b    <= op_a;
          end
        end
        CALC: begin
          p_q   <= p_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q   <= DONE;
            add_en    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            out_valid <= 1'b1;
            product   <= p_step;
          end else begin
            add_a <= p_step[PW-1:WIDTH];
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          add_en    <= 1'b0;
          add_a     <= '0;
          add_b     <= '0;
        end
      endcase
    end
  end

endmodule
